// File: rtl/bridge_pkg.sv
// Shared types and constants for the data-side SRAM to sram-like bridge.
//   bridge_state_t : FSM state encoding (IDLE, ADDR, DATA, DONE)
//   SIZE_*         : bus transfer size codes driven on data_size
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } bridge_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/wen_to_size.sv
// Decodes the core's byte write enables into sram-like request fields.
//   wen     in  4  byte write enables, 0000 = read
//   wr      out 1  1 = write
//   size    out 2  transfer size (byte/half/word)
//   addr_lo out 2  low address bits for the bus address
// Reads and irregular enable patterns fall back to an aligned word.
module wen_to_size
  import bridge_pkg::*;
(
  input  logic [3:0] wen,
  output logic       wr,
  output logic [1:0] size,
  output logic [1:0] addr_lo
);

  always_comb begin
    wr      = |wen;
    size    = SIZE_WORD;
    addr_lo = 2'd0;
    case (wen)
      4'b0001: begin size = SIZE_BYTE; addr_lo = 2'd0; end
      4'b0010: begin size = SIZE_BYTE; addr_lo = 2'd1; end
      4'b0100: begin size = SIZE_BYTE; addr_lo = 2'd2; end
      4'b1000: begin size = SIZE_BYTE; addr_lo = 2'd3; end
      4'b0011: begin size = SIZE_HALF; addr_lo = 2'd0; end
      4'b1100: begin size = SIZE_HALF; addr_lo = 2'd2; end
      default: begin size = SIZE_WORD; addr_lo = 2'd0; end
    endcase
  end

endmodule

// File: rtl/data_sram_like_bridge.sv
// Converts the core's single-cycle SRAM-style data port into a sram-like
// req/addr_ok/data_ok handshake, stalling the pipeline until done.
//   clk, resetn                 clock, synchronous active-low reset
//   data_sram_en/wen/addr/wdata core request
//   data_sram_rdata             registered read result to the core
//   longest_stall               pipeline frozen by another source
//   d_stall                     hold pipeline, access outstanding
//   data_req/wr/size/addr/wdata bus request
//   data_addr_ok/data_ok/rdata  bus handshake and read data
module data_sram_like_bridge
  import bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  input  logic              longest_stall,
  output logic              d_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  bridge_state_t     state, state_nxt;
  logic [3:0]        wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        addr_lo;
  logic              rd_done;

  wen_to_size u_wen_to_size (
    .wen     (wen_q),
    .wr      (data_wr),
    .size    (data_size),
    .addr_lo (addr_lo)
  );

  assign data_addr  = {addr_q[ADDR_W-1:2], addr_lo};
  assign data_wdata = wdata_q;
  assign d_stall    = data_sram_en & (state != DONE);

  // Read data lands either with a combined addr_ok/data_ok in ADDR or with
  // the later data_ok in DATA.
  assign rd_done = !data_wr && data_data_ok &&
                   ((state == ADDR && data_addr_ok) || state == DATA);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= IDLE;
      data_sram_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (rd_done) data_sram_rdata <= data_rdata;
    end
  end

  // Request fields are held stable from capture until the next IDLE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wen_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && data_sram_en) begin
      wen_q   <= data_sram_wen;
      addr_q  <= data_sram_addr;
      wdata_q <= data_sram_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    data_req  = 1'b0;
    case (state)
      IDLE: if (data_sram_en) state_nxt = ADDR;
      ADDR: begin
        data_req = 1'b1;
        if (data_addr_ok) state_nxt = data_data_ok ? DONE : DATA;
      end
      DATA: if (data_data_ok) state_nxt = DONE;
      DONE: if (!longest_stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Scoreboard bench: stimulus pushes the expected bus request for every cycle
// data_req should be high, and the expected read result for every completed
// access; two monitors pop and compare when the DUT presents them.
module tb_data_sram_like_bridge;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        longest_stall;
  logic        d_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int vectors = 0;
  int miscompares = 0;
  req_t        exp_req[$];
  logic [31:0] exp_rd[$];

  data_sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .longest_stall   (longest_stall),
    .d_stall         (d_stall),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_size       (data_size),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok    (data_data_ok),
    .data_rdata      (data_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Request monitor: every cycle with data_req high must match the head.
  always @(negedge clk) begin
    if (data_req) begin
      req_t got, e;
      got = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
      vectors++;
      if (exp_req.size() == 0) begin
        miscompares++;
        $display("FAIL req_unexpected got wr=%0b size=%0d addr=%h wdata=%h",
                 data_wr, data_size, data_addr, data_wdata);
      end else begin
        e = exp_req.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL req_fields got wr=%0b size=%0d addr=%h wdata=%h exp wr=%0b size=%0d addr=%h wdata=%h",
                   data_wr, data_size, data_addr, data_wdata, e.wr, e.size, e.addr, e.wdata);
        end
      end
    end
  end

  // Completion monitor: en high with stall released means the access retired.
  always @(negedge clk) begin
    if (resetn && data_sram_en && !d_stall) begin
      logic [31:0] e;
      vectors++;
      if (exp_rd.size() == 0) begin
        miscompares++;
        $display("FAIL done_unexpected got rdata=%h", data_sram_rdata);
      end else begin
        e = exp_rd.pop_front();
        if (data_sram_rdata !== e) begin
          miscompares++;
          $display("FAIL done_rdata got %h exp %h", data_sram_rdata, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  // One core access. a_wait: cycles of req before addr_ok. same: data_ok with
  // addr_ok. d_wait: idle cycles in DATA before data_ok. Called in IDLE, #1
  // after an edge; returns #1 after the edge following the DONE cycle.
  task automatic access(input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input int a_wait, input bit same,
                        input int d_wait, input logic [31:0] bus_rd,
                        input req_t er, input logic [31:0] exp_rdata);
    for (int i = 0; i <= a_wait; i++) exp_req.push_back(er);
    exp_rd.push_back(exp_rdata);
    data_sram_en = 1'b1; data_sram_wen = wen;
    data_sram_addr = addr; data_sram_wdata = wdata;
    #1;
    chk("stall_on_en", {31'd0, d_stall}, 32'd1);
    chk("no_req_c0", {31'd0, data_req}, 32'd0);
    @(posedge clk); #1;
    chk("req_c1", {31'd0, data_req}, 32'd1);
    repeat (a_wait) begin @(posedge clk); #1; end
    data_addr_ok = 1'b1; data_data_ok = same; data_rdata = bus_rd;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h5555_5555;
    if (!same) begin
      repeat (d_wait) begin @(posedge clk); #1; end
      data_data_ok = 1'b1; data_rdata = bus_rd;
      @(posedge clk); #1;
      data_data_ok = 1'b0; data_rdata = 32'h5555_5555;
    end
    @(posedge clk); #1;
    data_sram_en = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; data_sram_en = 1'b0; data_sram_wen = 4'h0;
    data_sram_addr = '0; data_sram_wdata = '0; longest_stall = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h5555_5555;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, data_req}, 32'd0);
    chk("rst_rdata", data_sram_rdata, 32'd0);
    chk("rst_stall", {31'd0, d_stall}, 32'd0);
    resetn = 1'b1;

    // Stray handshakes in IDLE are ignored.
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    chk("idle_ok_ignored", data_sram_rdata, 32'd0);

    access(4'b0000, 32'h8000_1006, 32'h0, 1, 1'b0, 1, 32'hDEAD_BEEF,
           '{1'b0, 2'd2, 32'h8000_1004, 32'h0}, 32'hDEAD_BEEF);
    access(4'b0100, 32'hBFAF_F000, 32'h00AB_0000, 0, 1'b1, 0, 32'h1111_1111,
           '{1'b1, 2'd0, 32'hBFAF_F002, 32'h00AB_0000}, 32'hDEAD_BEEF);
    access(4'b1100, 32'hBFAF_F000, 32'h1234_0000, 0, 1'b0, 0, 32'h2222_2222,
           '{1'b1, 2'd1, 32'hBFAF_F002, 32'h1234_0000}, 32'hDEAD_BEEF);
    access(4'b0101, 32'h1000_0003, 32'h00FF_00FF, 0, 1'b1, 0, 32'h0,
           '{1'b1, 2'd2, 32'h1000_0000, 32'h00FF_00FF}, 32'hDEAD_BEEF);
    access(4'b0001, 32'hA000_0007, 32'h0000_0011, 0, 1'b1, 0, 32'h0,
           '{1'b1, 2'd0, 32'hA000_0004, 32'h0000_0011}, 32'hDEAD_BEEF);
    access(4'b0010, 32'hA000_0004, 32'h0000_2200, 0, 1'b1, 0, 32'h0,
           '{1'b1, 2'd0, 32'hA000_0005, 32'h0000_2200}, 32'hDEAD_BEEF);
    access(4'b1000, 32'hA000_0004, 32'h4400_0000, 0, 1'b1, 0, 32'h0,
           '{1'b1, 2'd0, 32'hA000_0007, 32'h4400_0000}, 32'hDEAD_BEEF);
    access(4'b0011, 32'hA000_000E, 32'h0000_5566, 0, 1'b0, 2, 32'h0,
           '{1'b1, 2'd1, 32'hA000_000C, 32'h0000_5566}, 32'hDEAD_BEEF);
    access(4'b1111, 32'hA000_0011, 32'h8899_AABB, 0, 1'b1, 0, 32'h0,
           '{1'b1, 2'd2, 32'hA000_0010, 32'h8899_AABB}, 32'hDEAD_BEEF);
    // addr_ok withheld for 5 cycles: 6 identical request cycles.
    access(4'b0000, 32'h0000_0043, 32'hCCCC_CCCC, 5, 1'b0, 0, 32'h1234_5678,
           '{1'b0, 2'd2, 32'h0000_0040, 32'hCCCC_CCCC}, 32'h1234_5678);
    access(4'b0000, 32'h1FC0_0008, 32'h0, 0, 1'b1, 0, 32'hCAFE_F00D,
           '{1'b0, 2'd2, 32'h1FC0_0008, 32'h0}, 32'hCAFE_F00D);

    // Freeze after completion.
    longest_stall = 1'b1;
    access(4'b0000, 32'h0000_0100, 32'h0, 0, 1'b0, 0, 32'h0BAD_C0DE,
           '{1'b0, 2'd2, 32'h0000_0100, 32'h0}, 32'h0BAD_C0DE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("freeze_req", {31'd0, data_req}, 32'd0);
      chk("freeze_rdata", data_sram_rdata, 32'h0BAD_C0DE);
    end
    @(posedge clk); #1;
    longest_stall = 1'b0;             // falls while still in DONE
    @(posedge clk); #1;               // IDLE
    chk("unfreeze_no_req", {31'd0, data_req}, 32'd0);
    access(4'b0000, 32'h0000_0200, 32'h0, 0, 1'b1, 0, 32'h7777_0000,
           '{1'b0, 2'd2, 32'h0000_0200, 32'h0}, 32'h7777_0000);

    // Reset while in DATA; the late data_ok must be dropped.
    exp_req.push_back('{1'b0, 2'd2, 32'h0000_0300, 32'h0});
    data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h0000_0300;
    data_sram_wdata = 32'h0;
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;               // DATA
    data_addr_ok = 1'b0; resetn = 1'b0; data_sram_en = 1'b0;
    @(posedge clk); #1;
    chk("abort_req", {31'd0, data_req}, 32'd0);
    chk("abort_rdata", data_sram_rdata, 32'd0);
    resetn = 1'b1;
    data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    chk("late_ok_dropped", data_sram_rdata, 32'd0);
    chk("stall_en_low", {31'd0, d_stall}, 32'd0);
    access(4'b0000, 32'h0000_0404, 32'h0, 0, 1'b1, 0, 32'h0A0B_0C0D,
           '{1'b0, 2'd2, 32'h0000_0404, 32'h0}, 32'h0A0B_0C0D);

    repeat (3) @(posedge clk);
    #1;
    chk("req_queue_empty", exp_req.size(), 32'd0);
    chk("rd_queue_empty", exp_rd.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_sram_like_bridge.md
Name: data_sram_like_bridge

Overview:
- Downstream neighbour of the CPU top's data-side SRAM port.
- Converts the single-cycle SRAM-style request from the mips core (en/wen/addr/wdata, with rdata expected next cycle) into a sram-like split handshake (req/addr_ok/data_ok).
- Back-pressures the pipeline through a stall output.
- Sits between the core's data port and the external data bus (cache or AXI shim).

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  synchronous reset, active-low.
- data_sram_en  in  1  core issues data access this cycle.
- data_sram_wen  in  4  byte write enables; 0000 = read.
- data_sram_addr  in  ADDR_W  byte address.
- data_sram_wdata  in  DATA_W  write data, lane-aligned.
- data_sram_rdata  out  DATA_W  registered read result.
- longest_stall  in  1  pipeline frozen by another source.
- d_stall  out  1  hold pipeline; access not yet complete.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  ADDR_W  bus address.
- data_wdata  out  DATA_W  bus write data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response or write-complete.
- data_rdata  in  DATA_W  bus read data, valid with data_data_ok.

Behaviour:
- State machine states: IDLE, ADDR, DATA, DONE. Reset (resetn=0 at an edge) -> IDLE.
- Output reset values: data_sram_rdata = 0, data_req = 0. data_wr, data_size, data_addr and data_wdata are don't-care while data_req = 0; they are driven from the captured request.
- IDLE:
  - en=1 -> capture wen/addr/wdata, go to ADDR.
  - en=0 -> stay in IDLE.
- ADDR:
  - data_req=1.
  - addr_ok=1 and data_ok=1 in the same cycle -> DONE.
  - addr_ok=1 only -> DATA.
  - addr_ok=0 -> stay in ADDR, request fields held stable.
  - data_ok without addr_ok is ignored.
- DATA:
  - data_req=0.
  - data_ok=1 -> DONE. For reads, data_sram_rdata <= data_rdata on this edge.
- DONE:
  - longest_stall=1 -> stay in DONE, no new request.
  - longest_stall=0 -> IDLE.
- Writes never modify data_sram_rdata.
- d_stall = data_sram_en & (state != DONE), combinational. It is asserted in the same cycle en rises.
- Minimum latency from en to stall release: 2 cycles (IDLE -> ADDR with addr_ok and data_ok together -> DONE).
- Read request encoding: data_wr=0, data_size=2, data_addr = {addr[ADDR_W-1:2], 2'b00}. The core extracts bytes itself.
- Write request encoding (data_wr=1), by wen:
  - 0001 / 0010 / 0100 / 1000 -> size 0, addr[1:0] = 0 / 1 / 2 / 3.
  - 0011 -> size 1, addr[1:0] = 0.
  - 1100 -> size 1, addr[1:0] = 2.
  - 1111 -> size 2, addr[1:0] = 0.
  - Any other non-zero pattern -> size 2, addr[1:0] = 0.
- data_wdata = captured wdata, unmodified.
- data_ok or addr_ok arriving in IDLE or DONE is ignored.
- Reset during ADDR or DATA -> IDLE next edge, data_req=0. A late data_ok for the aborted transfer is dropped.
- Back-to-back accesses: DONE -> IDLE, then a new capture. There is at least one IDLE cycle between bus requests.

Decomposition:
- Shared package bridge_pkg holds:
  - typedef enum bridge_state_t {IDLE, ADDR, DATA, DONE}.
  - Constants SIZE_BYTE=2'd0, SIZE_HALF=2'd1, SIZE_WORD=2'd2.
- One combinational sub-module, wen_to_size. Input wen[3:0]; outputs wr, size[1:0], addr_lo[1:0]. It is instantiated once on the captured wen.

Test Plan:
- Read: en=1, wen=0000, addr=0x8000_1006.
  - c0: stall=1, req=0.
  - c1: req=1, addr=0x8000_1004, size=2, wr=0.
  - addr_ok at c2, then data_ok with 0xDEADBEEF at c4.
  - Required: stall=0 at c5, data_sram_rdata=0xDEADBEEF.
- Byte write: wen=0100, addr=0xBFAF_F000, wdata=0x00AB_0000, addr_ok and data_ok both at c1.
  - Required: wr=1, size=0, addr=0xBFAF_F002, wdata=0x00AB_0000; stall=0 at c2.
  - Required: rdata unchanged.
- Halfword write: wen=1100 -> size=1, addr[1:0]=2.
- Odd wen=0101 -> size=2, addr[1:0]=0.
- addr_ok held low 5 cycles: req stays 1 with identical addr/size/wdata every cycle; stall stays 1.
- Freeze after completion: longest_stall=1 for 3 cycles after DONE.
  - Required: no req, stall=0, rdata stable.
  - After longest_stall=0: state returns to IDLE; a second read issues req exactly 2 cycles after longest_stall falls.
- Reset mid-transfer: resetn=0 during DATA.
  - Required: req=0 and rdata=0 on the next edge.
  - A data_ok pulse after reset is ignored (rdata stays 0); stall then follows en.
